// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line idle level and the
// clocks-per-bit helper used by the receiver, transmitter and delay stages.
package uart_pkg;

  typedef enum logic [1:0] {
    UartIdle  = 2'd0,
    UartStart = 2'd1,
    UartData  = 2'd2,
    UartStop  = 2'd3
  } uart_state_e;

  localparam logic LineIdle = 1'b1;

  function automatic int unsigned cyc_per_bit(input int unsigned sys_clk,
                                              input int unsigned baud);
    return sys_clk / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side serial line and byte/strobe outputs of uart_rx.
interface uart_rx_if;

  logic       din;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output din,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  din,
    output data,
    output valid,
    output frame_err,
    output busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line, one extra delay
// flop and falling-edge detect. All flops reset to the idle-high level.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic din_s_o,
  output logic fall_o
);

  logic meta_q, meta_d;
  logic din_s_q, din_s_d;
  logic din_d_q, din_d_d;

  always_comb begin
    meta_d  = din_i;
    din_s_d = meta_q;
    din_d_d = din_s_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q  <= LineIdle;
      din_s_q <= LineIdle;
      din_d_q <= LineIdle;
    end else begin
      meta_q  <= meta_d;
      din_s_q <= din_s_d;
      din_d_q <= din_d_d;
    end
  end

  assign din_s_o = din_s_q;
  assign fall_o  = din_d_q & ~din_s_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a down-counting baud timer on the system clock.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling (one cycle later).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYSTEM_CLOCK = 32000000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned CYC_COUNT    = cyc_per_bit(SYSTEM_CLOCK, BAUD_RATE),
  parameter int unsigned CYC_HALF     = CYC_COUNT / 2
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);

  localparam int unsigned CntW = $clog2(CYC_COUNT);
  localparam logic [CntW-1:0] CntFull = CntW'(CYC_COUNT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CYC_HALF - 1);

  localparam logic [1:0] StIdle  = UartIdle;
  localparam logic [1:0] StStart = UartStart;
  localparam logic [1:0] StData  = UartData;
  localparam logic [1:0] StStop  = UartStop;

  logic            din_s;
  logic            fall;
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            expire;
  logic            smp_stb;
  logic            smp;

  uart_rx_sync u_sync (
    .clk_i   (clk),
    .rst_i   (rst),
    .din_i   (bus.din),
    .din_s_o (din_s),
    .fall_o  (fall)
  );

  assign expire = (state_q != StIdle) && (cnt_q == '0);

`ifdef UART_RX_MAJORITY_EN
  // Keep the two previous line samples; the decision is taken one cycle after
  // the nominal edge so that the sample after it is also available.
  logic [1:0] hist_q, hist_d;
  logic       stb_q, stb_d;

  always_comb begin
    hist_d = {hist_q[0], din_s};
    stb_d  = expire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= {2{LineIdle}};
      stb_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      stb_q  <= stb_d;
    end
  end

  assign smp_stb = stb_q;
  assign smp     = (hist_q[1] & hist_q[0]) | (hist_q[1] & din_s) | (hist_q[0] & din_s);
`else
  assign smp_stb = expire;
  assign smp     = din_s;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    // The timer free-runs with reload while a frame is in progress.
    if (state_q != StIdle) begin
      cnt_d = expire ? CntFull : cnt_q - 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (fall) begin
          state_d = StStart;
          cnt_d   = CntHalf;
        end
      end
      StStart: begin
        if (smp_stb) begin
          if (smp == LineIdle) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            idx_d   = 3'd0;
          end
        end
      end
      StData: begin
        if (smp_stb) begin
          shreg_d = {smp, shreg_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (smp_stb) begin
          state_d = StIdle;
          if (smp == LineIdle) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shreg_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus random frames checked against a
// waveform-sampling reference model (16 clocks per bit).
module tb_uart_rx;

  localparam int unsigned SysClk = 160000;
  localparam int unsigned Baud   = 10000;
`ifdef UART_RX_MAJORITY_EN
  localparam int Maj = 1;
`else
  localparam int Maj = 0;
`endif
  localparam int FrameLen = 160;

  typedef struct {
    int         cyc;
    bit         err;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  ev_t  exp_q[$];
  logic [7:0] model_data = 8'h00;
  bit   wave[FrameLen];
  bit   prev_stb = 1'b0;

  uart_rx_if bus ();

  uart_rx #(
    .SYSTEM_CLOCK (SysClk),
    .BAUD_RATE    (Baud)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic hold(input logic v, input int n);
    bus.din = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Line waveform of one frame, one entry per clock; glitch inverts one clock.
  function automatic void build_wave(input logic [7:0] b, input bit stop, input int glitch);
    for (int i = 0; i < FrameLen; i++) begin
      int j;
      bit v;
      j = i / 16;
      if (j == 0) v = 1'b0;
      else if (j < 9) v = b[j-1];
      else v = stop;
      if (i == glitch) v = ~v;
      wave[i] = v;
    end
  endfunction

  // Receiver view of the line at bit-centre p (offset from the start edge).
  function automatic bit sample_at(input int p);
    if (Maj == 1) return (int'(wave[p-1]) + int'(wave[p]) + int'(wave[p+1])) >= 2;
    return wave[p];
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit stop, input int glitch,
                            input int tail_low);
    int         c0;
    logic [7:0] d;
    build_wave(b, stop, glitch);
    c0 = cyc;
    if (!sample_at(8)) begin
      for (int k = 0; k < 8; k++) d[k] = sample_at(24 + 16 * k);
      if (sample_at(152)) begin
        exp_q.push_back('{cyc: c0 + 3 + 152 + Maj, err: 1'b0, data: d});
        model_data = d;
      end else begin
        exp_q.push_back('{cyc: c0 + 3 + 152 + Maj, err: 1'b1, data: model_data});
      end
    end
    for (int i = 0; i < FrameLen; i++) begin
      bus.din = wave[i];
      @(posedge clk);
      #1;
    end
    if (tail_low > 0) hold(1'b0, tail_low);
  endtask

  // Strobe monitor: every strobe must match the next expected event.
  always @(posedge clk) begin
    #1;
    if (bus.valid || bus.frame_err) begin
      check_eq("strobe_excl", 32'(bus.valid & bus.frame_err), 32'd0);
      check_eq("strobe_len", 32'(prev_stb), 32'd0);
      check_eq("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        ev_t e;
        e = exp_q.pop_front();
        check_eq("strobe_cyc", cyc, e.cyc);
        check_eq("strobe_kind", 32'(bus.frame_err), 32'(e.err));
        check_eq("strobe_data", 32'(bus.data), 32'(e.data));
      end
    end
    prev_stb = bus.valid | bus.frame_err;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.din = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data", 32'(bus.data), 32'h00);
    check_eq("rst_valid", 32'(bus.valid), 32'd0);
    check_eq("rst_ferr", 32'(bus.frame_err), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    hold(1'b1, 20);

    // Single frame
    send_frame(8'h55, 1'b1, -1, 0);
    hold(1'b1, 20);
    check_eq("f55_data", 32'(bus.data), 32'h55);

    // Back-to-back frames, 160 clocks apart
    send_frame(8'hA3, 1'b1, -1, 0);
    send_frame(8'h0F, 1'b1, -1, 0);
    hold(1'b1, 20);
    check_eq("b2b_data", 32'(bus.data), 32'h0F);
    check_eq("b2b_pending", exp_q.size(), 0);

    // 4-cycle low glitch: false start, busy from t0 (c0+3) to t0+8
    begin
      int c0;
      c0 = cyc;
      bus.din = 1'b0;
      for (int i = 0; i < 20; i++) begin
        int k;
        if (i == 4) bus.din = 1'b1;
        @(posedge clk);
        #1;
        k = cyc - c0;
        if (k == 2) check_eq("glitch_busy_pre", 32'(bus.busy), 32'd0);
        if (k == 3) check_eq("glitch_busy_t0", 32'(bus.busy), 32'd1);
        if (k == 10 + Maj) check_eq("glitch_busy_hold", 32'(bus.busy), 32'd1);
        if (k == 11 + Maj) check_eq("glitch_busy_fall", 32'(bus.busy), 32'd0);
      end
    end
    hold(1'b1, 20);

    // Frame error followed by a 40-bit break
    send_frame(8'hFF, 1'b0, -1, 640);
    check_eq("break_busy", 32'(bus.busy), 32'd0);
    check_eq("break_data", 32'(bus.data), 32'h0F);
    hold(1'b1, 32);
    send_frame(8'h3C, 1'b1, -1, 0);
    hold(1'b1, 20);
    check_eq("after_break_data", 32'(bus.data), 32'h3C);

    // Reset during data bit 4 of 0x96
    build_wave(8'h96, 1'b1, -1);
    for (int i = 0; i < 88; i++) begin
      bus.din = wave[i];
      @(posedge clk);
      #1;
    end
    check_eq("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("midrst_data", 32'(bus.data), 32'h00);
    check_eq("midrst_valid", 32'(bus.valid), 32'd0);
    check_eq("midrst_ferr", 32'(bus.frame_err), 32'd0);
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);
    model_data = 8'h00;
    @(posedge clk);
    #1;
    hold(1'b1, 40);
    rst = 1'b0;
    hold(1'b1, 32);
    check_eq("post_rst_data", 32'(bus.data), 32'h00);
    send_frame(8'h3C, 1'b1, -1, 0);
    hold(1'b1, 20);
    check_eq("post_rst_rx", 32'(bus.data), 32'h3C);

    // 1-cycle high glitch on the bit-2 sample point of 0x00
    send_frame(8'h00, 1'b1, 56, 0);
    hold(1'b1, 20);
    check_eq("bit2_glitch_data", 32'(bus.data), (Maj == 1) ? 32'h00 : 32'h04);

    // Random frames, some with bad stop bits or single-cycle glitches
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      bit         stop;
      int         gl;
      int         gap;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      gl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16, 150)) : -1;
      send_frame(b, stop, gl, 0);
      gap  = stop ? int'($urandom_range(0, 20)) : int'($urandom_range(2, 20));
      hold(1'b1, gap);
    end

    hold(1'b1, 40);
    check_eq("final_pending", exp_q.size(), 0);
    check_eq("final_busy", 32'(bus.busy), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8N1, LSB first, line idle high. Sits directly downstream of the serial delay line: it consumes that block's delayed `dout` as its `din` and turns frames into bytes with a one-cycle strobe. It runs on the full system clock, with no divided clock, and resolves mid-bit sampling with a baud counter.

## Interface
- `SYSTEM_CLOCK`, default 32000000: clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bit/s.
- `CYC_COUNT`, default SYSTEM_CLOCK/BAUD_RATE (3333): clocks per bit, derived.
- `CYC_HALF`, default CYC_COUNT/2 (1666): start-bit centring delay, derived.
- `clk`, input, 1: system clock. Single clock domain.
- `rst`, input, 1: reset. Asynchronous, active-high.
- `din`, input, 1: serial line, asynchronous to `clk`.
- `data`, output, 8: last correctly received byte.
- `valid`, output, 1: one-cycle strobe; `data` is new.
- `frame_err`, output, 1: one-cycle strobe; stop bit was sampled low.
- `busy`, output, 1: high from start detection until return to IDLE.

## Operation
- Input path: 2-FF synchronizer giving `din_s`, plus a registered `din_d`.
  - Falling edge: `din_d`=1 and `din_s`=0.
  - Synchronizer flops reset to 1.
- States:
  - IDLE: on falling edge → START; load the baud counter with CYC_HALF−1; set `busy`.
  - START: when the counter expires, sample.
    - Sample 0 → DATA, bit index 0, counter reloads CYC_COUNT−1.
    - Sample 1 → false start: IDLE, no strobe.
  - DATA: on each expiry, shift the sample into bit [7] of the shift register (LSB first). After index 7 → STOP.
  - STOP: on expiry, sample.
    - Sample 1: `data`←shift register and pulse `valid`.
    - Sample 0: pulse `frame_err`; `data` is unchanged.
    - Either case → IDLE.
- Re-arm after STOP occurs mid-stop-bit, so back-to-back frames are accepted.
- After a frame error the line may still be low (break). IDLE only re-arms on a true falling edge, so a receiver waits for the line to return high.
- Baud counter width is $clog2(CYC_COUNT). It counts down and reloads on expiry, with no wrap ambiguity.
- `valid` and `frame_err` are mutually exclusive and never high for more than 1 cycle.
- Reset values: `data`=8'h00, `valid`=0, `frame_err`=0, `busy`=0, state IDLE, counters 0.
- `rst` mid-frame aborts immediately. No strobe is issued, and the next falling edge after release starts a fresh frame.

## Timing
- t0 is the `clk` edge at which the falling edge is detected, i.e. 2–3 cycles after the physical `din` edge.
- Sample edges:
  - Start bit: t0+CYC_HALF.
  - Data bit k: t0+CYC_HALF+(k+1)·CYC_COUNT.
  - Stop bit: t0+CYC_HALF+9·CYC_COUNT.
- `valid`/`frame_err` are registered at the stop-sample edge. They are high for exactly the following cycle, and `data` is updated on the same edge.
- `busy` falls on the stop-sample edge, or on the start-sample edge for a false start.
- Tolerates ±4 % baud mismatch without bit slip.

## Configuration
- Macro `UART_RX_MAJORITY_EN`.
- Defined:
  - Every sample (start, data, stop) is the 2-of-3 majority of `din_s` at the nominal edge −1, 0 and +1.
  - Each decision, and therefore every strobe, moves 1 cycle later than the Timing figures.
  - Rejects single-cycle glitches.
- Undefined: single sample at the nominal edge, exact timing as above.

## Structure
- Package `uart_pkg`:
  - State enum (IDLE, START, DATA, STOP).
  - Line idle level constant.
  - Function computing clocks per bit from SYSTEM_CLOCK/BAUD_RATE, shared with the transmitter and delay stages.
- Sub-module `uart_rx_sync`: 2-FF synchronizer, `din_d` register and falling-edge detect. It resets to idle-high.

## Test plan
Simulation uses SYSTEM_CLOCK=160000 and BAUD_RATE=10000, so CYC_COUNT=16 and CYC_HALF=8.
- Frame 0x55: `valid` is high for 1 cycle at t0+152+1, `data`=0x55, `frame_err` stays 0.
- Back-to-back 0xA3 then 0x0F, each with a one-bit stop: two `valid` strobes exactly 160 cycles apart, data 0xA3 then 0x0F.
- 4-cycle low glitch on idle line: no strobe; `busy` is high from t0 and falls at t0+8.
- 0xFF sent with stop bit 0, then line held low for 40 bit times:
  - `frame_err` pulses once and `data` keeps its previous value.
  - No further activity until the line goes high; then 0x3C is received correctly.
- `rst` asserted during data bit 4 of 0x96:
  - All outputs are 0 immediately and no strobe follows.
  - After release, 0x3C is received correctly.
- 1-cycle high glitch exactly at the bit-2 sample of 0x00:
  - With `UART_RX_MAJORITY_EN`: `data`=0x00.
  - Without: `data`=0x04.
